// File: rtl/jtag_ctap_ir_bank.sv
// Multi-channel JTAG instruction register bank: one shared capture/shift register
// committed to a latched channel on a guarded update. Optional JTAG_CTAP_LOCK_EN adds sticky per-channel locks.
module jtag_ctap_ir_bank #(
    parameter int IR_W = 5,
    parameter int NCH = 4,
    parameter logic [IR_W-1:0] RST_INST = '1,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     capture_en,
    input  logic                     shift_en,
    input  logic                     update_en,
    input  logic                     addr_wr_en,
    input  logic                     tdi,
    output logic                     tdo,
    output logic [NCH*IR_W-1:0]      inst_out,
    output logic [NCH-1:0]           inst_wr_en,
    output logic                     upd_err
);
    localparam int CNT_W = $clog2(IR_W + 2);
    localparam logic [IR_W-1:0] CAP_PAT = IR_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPD} state_t;

    state_t                     state, state_nx;
    logic [IR_W-1:0]            sr;
    logic [CNT_W-1:0]           cnt;
    logic [CH_W-1:0]            ch_q;
    logic [NCH-1:0][IR_W-1:0]   inst_q;
    logic                       do_upd, do_cap, do_shift;
    logic                       ch_ok, locked, commit, reject;

    // update_en masks the other strobes even when it is itself ignored
    assign do_upd   = update_en && (state == SHIFT);
    assign do_cap   = !update_en && capture_en;
    assign do_shift = !update_en && !capture_en && shift_en && (state == SHIFT);

    assign ch_ok  = int'(ch_q) < NCH;

`ifdef JTAG_CTAP_LOCK_EN
    logic [NCH-1:0] lock;
    assign locked = ch_ok ? lock[ch_q] : 1'b0;
`else
    assign locked = 1'b0;
`endif

    assign commit = (state == UPD) && addr_wr_en && (int'(cnt) == IR_W) && ch_ok && !locked;
    assign reject = (state == UPD) && !commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == UPD) state_nx = IDLE;
        if (do_upd)       state_nx = UPD;
        else if (do_cap)  state_nx = SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            ch_q    <= '0;
            tdo     <= 1'b0;
            upd_err <= 1'b0;
        end else begin
            upd_err <= reject;
            if (do_cap) begin
                sr   <= CAP_PAT;
                cnt  <= '0;
                ch_q <= ch_sel;
            end else if (do_shift) begin
                sr  <= {tdi, sr[IR_W-1:1]};
                tdo <= sr[0];
                if (int'(cnt) < IR_W + 1) cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr;
        assign wr = commit && (ch_q == CH_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                inst_q[i]     <= RST_INST;
                inst_wr_en[i] <= 1'b0;
            end else begin
                inst_wr_en[i] <= wr;
                if (wr) inst_q[i] <= sr;
            end
        end

`ifdef JTAG_CTAP_LOCK_EN
        // an all-zeros instruction freezes the channel until reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                  lock[i] <= 1'b0;
            else if (wr && sr == '0)  lock[i] <= 1'b1;
        end
`endif
    end

    assign inst_out = inst_q;

endmodule

// File: tb/tb_jtag_ctap_ir_bank.sv
// Scoreboard bench for jtag_ctap_ir_bank (IR_W=5, NCH=4); lock behaviour follows JTAG_CTAP_LOCK_EN.
module tb_jtag_ctap_ir_bank;
    localparam int IR_W = 5;
    localparam int NCH  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       ch_sel = '0;
    logic             capture_en = 1'b0, shift_en = 1'b0, update_en = 1'b0;
    logic             addr_wr_en = 1'b0, tdi = 1'b0;
    logic             tdo;
    logic [19:0]      inst_out;
    logic [3:0]       inst_wr_en;
    logic             upd_err;

    jtag_ctap_ir_bank #(.IR_W(IR_W), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .ch_sel(ch_sel), .capture_en(capture_en),
        .shift_en(shift_en), .update_en(update_en), .addr_wr_en(addr_wr_en),
        .tdi(tdi), .tdo(tdo), .inst_out(inst_out), .inst_wr_en(inst_wr_en),
        .upd_err(upd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wr;
        logic        err;
        logic [19:0] inst;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model
    logic [3:0][4:0] minst;
    logic [3:0]      mlock;
    logic [4:0]      msr;
    int              mcnt;
    logic [1:0]      mch;
    logic            mshift;
    logic            mtdo;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        minst  = {4{5'h1F}};
        mlock  = '0;
        msr    = '0;
        mcnt   = 0;
        mch    = '0;
        mshift = 1'b0;
        mtdo   = 1'b0;
    endtask

    task automatic capture(input logic [1:0] ch);
        ch_sel = ch; capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        msr = 5'b00001; mcnt = 0; mch = ch; mshift = 1'b1;
    endtask

    task automatic shift(input logic b);
        shift_en = 1'b1; tdi = b;
        tick();
        shift_en = 1'b0;
        if (mshift) begin
            mtdo = msr[0];
            msr  = {b, msr[4:1]};
            if (mcnt < IR_W + 1) mcnt++;
        end
        chk("tdo", tdo, mtdo);
    endtask

    task automatic shift_word(input logic [4:0] w, input int n);
        for (int i = 0; i < n; i++) shift(w[i % 5]);
    endtask

    // predict the outcome of an update strobe and queue it for the monitor
    task automatic model_update(input logic wr);
        evt_t e;
        logic ok;
        if (!mshift) return;
        ok = wr && (mcnt == IR_W) && !mlock[mch];
        if (ok) begin
            minst[mch] = msr;
`ifdef JTAG_CTAP_LOCK_EN
            if (msr == 5'b0) mlock[mch] = 1'b1;
`endif
        end
        e.wr = ok ? (4'b0001 << mch) : 4'b0000;
        e.err = !ok;
        e.inst = minst;
        exp_q.push_back(e);
        mshift = 1'b0;
    endtask

    task automatic update(input logic wr, input logic also_cap_shift);
        model_update(wr);
        addr_wr_en = wr; update_en = 1'b1;
        capture_en = also_cap_shift; shift_en = also_cap_shift;
        tick();
        update_en = 1'b0; capture_en = 1'b0; shift_en = 1'b0;
        tick();
        tick();
        addr_wr_en = 1'b0;
        chk("inst_hold", inst_out, minst);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", ($countones(inst_wr_en) > 1) ? 1 : 0, 0);
            if (inst_wr_en != 4'b0 || upd_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_evt", {inst_wr_en, upd_err}, 5'b0);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    chk("evt_wr", inst_wr_en, e.wr);
                    chk("evt_err", upd_err, e.err);
                    chk("evt_inst", inst_out, e.inst);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_reset();
        chk("rst_inst", inst_out, minst);
        chk("rst_wr", inst_wr_en, 4'b0);
        chk("rst_tdo", tdo, 1'b0);
        chk("rst_err", upd_err, 1'b0);
        chk("rst_x", $isunknown({tdo, inst_out, inst_wr_en, upd_err}), 1'b0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();
        chk("rst_const", inst_out, 20'hFFFFF);

        // capture pattern shifts out as 1,0,0,0,0
        capture(2'd0);
        shift_word(5'b00000, 5);
        update(1'b0, 1'b0);

        // successful commit to channel 2
        capture(2'd2);
        shift_word(5'b00110, 5);
        update(1'b1, 1'b0);
        chk("ch2_val", inst_out[14:10], 5'b00110);

        // shift and update in IDLE are ignored; tdo holds
        shift(1'b1);
        shift(1'b0);
        update(1'b1, 1'b0);

        // count errors: 4 and 6 shifts
        capture(2'd1);
        shift_word(5'b10101, 4);
        update(1'b1, 1'b0);
        capture(2'd1);
        shift_word(5'b10101, 6);
        update(1'b1, 1'b0);

        // simultaneous strobes in SHIFT take the update path
        capture(2'd3);
        shift_word(5'b10110, 5);
        update(1'b1, 1'b1);

        // lock behaviour (or plain commit without the lock feature)
        capture(2'd1);
        shift_word(5'b00000, 5);
        update(1'b1, 1'b0);
        capture(2'd1);
        shift_word(5'b00011, 5);
        update(1'b1, 1'b0);

        // reset during UPD aborts the commit and clears locks
        capture(2'd0);
        shift_word(5'b01010, 5);
        addr_wr_en = 1'b1; update_en = 1'b1;
        tick();
        update_en = 1'b0;
        do_reset();
        addr_wr_en = 1'b0;
        tick();
        chk("abort_inst", inst_out, 20'hFFFFF);

        capture(2'd1);
        shift_word(5'b00011, 5);
        update(1'b1, 1'b0);
        chk("relock_ch1", inst_out[9:5], 5'b00011);

        repeat (3) tick();
        chk("q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
